// File: rtl/dlatch_feeder_if.sv
// Word-in / half-word-out bundle between the upstream source, dlatch_feeder and the
// downstream latch. CntWidth must match the feeder instance it is bound to.
interface dlatch_feeder_if #(
    parameter int CntWidth = 8
);
    logic                Valid_i;
    logic [31:0]         Data_i;
    logic                Accept_o;
    logic                Stall_i;
    logic                Wen_o;
    logic [15:0]         Data_o;
    logic                Busy_o;
    logic [CntWidth-1:0] WordCnt_o;

    modport slave (
        input  Valid_i, Data_i, Stall_i,
        output Accept_o, Wen_o, Data_o, Busy_o, WordCnt_o
    );

    modport master (
        output Valid_i, Data_i, Stall_i,
        input  Accept_o, Wen_o, Data_o, Busy_o, WordCnt_o
    );
endinterface

// File: rtl/dlatch_feeder.sv
// Splits accepted 32-bit words into two strobed 16-bit writes for the dlatch register,
// with downstream stall between halves and a wrapping completed-word counter.
module dlatch_feeder #(
    parameter logic [31:0] Init     = 32'hDEADBEEF,
    parameter bit          LowFirst = 1'b1,
    parameter int          CntWidth = 8
) (
    input  logic           Clk_i,
    input  logic           Reset_n_i,
    dlatch_feeder_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_t;

    state_t              state_reg, state_next;
    logic [15:0]         data_reg, data_next;
    logic [15:0]         hold_reg, hold_next;
    logic                wen_reg, wen_next;
    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic                accept_c;
    logic                busy_c;

    logic [15:0] word_half [2];
    logic [15:0] first_half;
    logic [15:0] second_half;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            assign word_half[gi] = bus.Data_i[16*gi +: 16];
        end
    endgenerate

    assign first_half  = LowFirst ? word_half[0] : word_half[1];
    assign second_half = LowFirst ? word_half[1] : word_half[0];

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_reg <= S_IDLE;
            data_reg  <= Init[15:0];
            hold_reg  <= 16'h0000;
            wen_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            hold_reg  <= hold_next;
            wen_reg   <= wen_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        hold_next  = hold_reg;
        wen_next   = 1'b0;
        cnt_next   = cnt_reg;
        accept_c   = 1'b0;
        busy_c     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                accept_c = !bus.Stall_i;
                if (bus.Valid_i && accept_c) begin
                    data_next  = first_half;
                    hold_next  = second_half;
                    wen_next   = 1'b1;
                    state_next = S_SECOND;
                end
            end
            S_SECOND: begin
                busy_c = 1'b1;
                // A stall only postpones the held half; it is never dropped.
                if (!bus.Stall_i) begin
                    data_next  = hold_reg;
                    wen_next   = 1'b1;
                    cnt_next   = cnt_reg + {{(CntWidth-1){1'b0}}, 1'b1};
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Accept is gated by reset so upstream never sees a handshake while held in reset.
    assign bus.Accept_o  = accept_c & Reset_n_i;
    assign bus.Busy_o    = busy_c;
    assign bus.Wen_o     = wen_reg;
    assign bus.Data_o    = data_reg;
    assign bus.WordCnt_o = cnt_reg;
endmodule

// File: tb/tb_dlatch_feeder.sv
// Drives three feeder variants (default, 2-bit counter, high-half-first) with one
// shared stimulus stream and checks them every cycle against a word-level model.
module tb_dlatch_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = 32'h0;
    logic        stall = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dlatch_feeder_if              bus0 ();
    dlatch_feeder_if #(.CntWidth(2)) bus1 ();
    dlatch_feeder_if              bus2 ();

    assign bus0.Valid_i = valid;  assign bus0.Data_i = data;  assign bus0.Stall_i = stall;
    assign bus1.Valid_i = valid;  assign bus1.Data_i = data;  assign bus1.Stall_i = stall;
    assign bus2.Valid_i = valid;  assign bus2.Data_i = data;  assign bus2.Stall_i = stall;

    dlatch_feeder dut0 (.Clk_i(clk), .Reset_n_i(rst_n), .bus(bus0));
    dlatch_feeder #(.CntWidth(2)) dut1 (.Clk_i(clk), .Reset_n_i(rst_n), .bus(bus1));
    dlatch_feeder #(.LowFirst(1'b0)) dut2 (.Clk_i(clk), .Reset_n_i(rst_n), .bus(bus2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a word is either fully done or has one half outstanding.
    logic [31:0] m_word    = 32'h0;
    bit          m_pending = 1'b0;
    int          m_words   = 0;
    logic        m_wen     = 1'b0;
    logic [15:0] m_data [3] = '{16'hBEEF, 16'hBEEF, 16'hBEEF};
    bit          m_low [3]  = '{1'b1, 1'b1, 1'b0};
    int          m_cw  [3]  = '{8, 2, 8};

    function automatic logic [15:0] half_of(input logic [31:0] w, input bit second, input bit low_first);
        return (second ^ !low_first) ? w[31:16] : w[15:0];
    endfunction

    task automatic model_reset();
        m_pending = 1'b0;
        m_words   = 0;
        m_wen     = 1'b0;
        for (int i = 0; i < 3; i++) m_data[i] = 16'hBEEF;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else if (m_pending) begin
            if (!stall) begin
                for (int i = 0; i < 3; i++) m_data[i] = half_of(m_word, 1'b1, m_low[i]);
                m_wen     = 1'b1;
                m_pending = 1'b0;
                m_words++;
            end else begin
                m_wen = 1'b0;
            end
        end else if (valid && !stall) begin
            m_word = data;
            for (int i = 0; i < 3; i++) m_data[i] = half_of(m_word, 1'b0, m_low[i]);
            m_wen     = 1'b1;
            m_pending = 1'b1;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk("wen0", {31'b0, bus0.Wen_o}, {31'b0, m_wen});
        chk("wen1", {31'b0, bus1.Wen_o}, {31'b0, m_wen});
        chk("wen2", {31'b0, bus2.Wen_o}, {31'b0, m_wen});
        chk("data0", {16'b0, bus0.Data_o}, {16'b0, m_data[0]});
        chk("data1", {16'b0, bus1.Data_o}, {16'b0, m_data[1]});
        chk("data2", {16'b0, bus2.Data_o}, {16'b0, m_data[2]});
        chk("cnt0", {24'b0, bus0.WordCnt_o}, 32'(m_words % (1 << m_cw[0])));
        chk("cnt1", {30'b0, bus1.WordCnt_o}, 32'(m_words % (1 << m_cw[1])));
        chk("cnt2", {24'b0, bus2.WordCnt_o}, 32'(m_words % (1 << m_cw[2])));
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) model_reset();
        chk("accept0", {31'b0, bus0.Accept_o}, {31'b0, rst_n && !m_pending && !stall});
        chk("accept2", {31'b0, bus2.Accept_o}, {31'b0, rst_n && !m_pending && !stall});
        chk("busy0", {31'b0, bus0.Busy_o}, {31'b0, m_pending});
        chk("busy1", {31'b0, bus1.Busy_o}, {31'b0, m_pending});
    end

    // Presents words until n have been accepted; bounded so a dead handshake cannot hang.
    task automatic send_words(input int n, input bit counting);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            @(negedge clk);
            valid = 1'b1;
            stall = 1'b0;
            data  = counting ? {16'(2*i + 1), 16'(2*i + 2)} : $urandom;
            #1;
            if (bus0.Accept_o) i++;
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d accepted expected %0d", i, n);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        // Held in reset with a valid word on the bus.
        valid = 1'b1;
        data  = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_accept", {31'b0, bus0.Accept_o}, 32'h0);
        chk("rst_wen",    {31'b0, bus0.Wen_o}, 32'h0);
        chk("rst_data",   {16'b0, bus0.Data_o}, 32'h0000BEEF);
        chk("rst_cnt",    {24'b0, bus0.WordCnt_o}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;

        // Single word, no stall.
        @(negedge clk);
        valid = 1'b1;
        data  = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("t2_first",      {16'b0, bus0.Data_o}, 32'h0000F00D);
        chk("t2_first_hi",   {16'b0, bus2.Data_o}, 32'h0000CAFE);
        chk("t2_busy",       {31'b0, bus0.Busy_o}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("t2_second",     {16'b0, bus0.Data_o}, 32'h0000CAFE);
        chk("t2_second_hi",  {16'b0, bus2.Data_o}, 32'h0000F00D);
        chk("t2_wen",        {31'b0, bus0.Wen_o}, 32'h1);
        chk("t2_cnt",        {24'b0, bus0.WordCnt_o}, 32'h1);

        // Stall for three cycles between halves.
        @(negedge clk);
        valid = 1'b1;
        data  = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("t3_first", {16'b0, bus0.Data_o}, 32'h00005555);
        @(negedge clk);
        valid = 1'b0;
        stall = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t3_held_wen",  {31'b0, bus0.Wen_o}, 32'h0);
            chk("t3_held_data", {16'b0, bus0.Data_o}, 32'h00005555);
            @(negedge clk); #1;
            chk("t3_accept", {31'b0, bus0.Accept_o}, 32'h0);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        chk("t3_second", {16'b0, bus0.Data_o}, 32'h0000AAAA);
        chk("t3_cnt",    {24'b0, bus0.WordCnt_o}, 32'h2);

        // Four back-to-back words.
        send_words(4, 1'b1);
        @(posedge clk); #1;
        chk("t4_last", {16'b0, bus0.Data_o}, 32'h00000007);
        chk("t4_cnt",  {24'b0, bus0.WordCnt_o}, 32'h6);
        chk("t4_cnt2", {30'b0, bus1.WordCnt_o}, 32'h2);

        // Reset while the second half is pending.
        @(negedge clk);
        valid = 1'b1;
        data  = 32'h11112222;
        @(posedge clk); #1;
        chk("t5_first", {16'b0, bus0.Data_o}, 32'h00002222);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_data", {16'b0, bus0.Data_o}, 32'h0000BEEF);
        chk("t5_cnt",  {24'b0, bus0.WordCnt_o}, 32'h0);
        @(posedge clk); #1;
        chk("t5_wen",  {31'b0, bus0.Wen_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five words: narrow counter wraps through 1,2,3,0,1.
        send_words(5, 1'b0);
        @(posedge clk); #1;
        chk("t6_cnt",  {24'b0, bus0.WordCnt_o}, 32'h5);
        chk("t6_wrap", {30'b0, bus1.WordCnt_o}, 32'h1);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            valid = 1'($urandom_range(0, 1));
            data  = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
